// File: rtl/frame_sequencer_if.sv
// Bundle between the frame sequencer and the datapath it controls.
//   lane_enable   : per-lane NPC draw request (sampled once per frame)
//   collide_yes   : collision flag from the datapath
//   pause         : (FRAME_SEQUENCER_PAUSE_EN only) freezes the WAIT phase
//   erase_enable / draw_player_enable / draw_enable / wait_enable : phase strobes
//   draw_lane     : lane being drawn, valid with draw_enable
//   frame_done    : one-cycle pulse on the first WAIT cycle after a normal frame
//   game_over     : high once a collision has been seen
// master drives the requests (datapath / bench), slave is the sequencer.
interface frame_sequencer_if #(
  parameter int NUM_LANES = 3
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0] lane_enable;
  logic                 collide_yes;
`ifdef FRAME_SEQUENCER_PAUSE_EN
  logic                 pause;
`endif
  logic                 erase_enable;
  logic                 draw_player_enable;
  logic                 draw_enable;
  logic [LANE_W-1:0]    draw_lane;
  logic                 wait_enable;
  logic                 frame_done;
  logic                 game_over;

  modport master (
`ifdef FRAME_SEQUENCER_PAUSE_EN
    output pause,
`endif
    output lane_enable, collide_yes,
    input  erase_enable, draw_player_enable, draw_enable, draw_lane,
    input  wait_enable, frame_done, game_over
  );

  modport slave (
`ifdef FRAME_SEQUENCER_PAUSE_EN
    input  pause,
`endif
    input  lane_enable, collide_yes,
    output erase_enable, draw_player_enable, draw_enable, draw_lane,
    output wait_enable, frame_done, game_over
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: WAIT -> ERASE -> DRAWPLAYER -> DRAW (one phase per pending
// lane, ascending) -> WAIT, with GAMEOVER on a collision seen at the end of a
// draw phase. One shared phase counter times every phase.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   resetn : synchronous active-low reset
//   bus    : frame_sequencer_if.slave (requests in, phase strobes out)
// Optional feature: define FRAME_SEQUENCER_PAUSE_EN to add bus.pause, which
// holds the counter while in WAIT.
module frame_sequencer #(
  parameter int NUM_LANES     = 3,
  parameter int CTR_W         = 20,
  parameter int DRAW_CYCLES   = 630,
  parameter int PLAYER_CYCLES = 630,
  parameter int ERASE_CYCLES  = 19200,
  parameter int WAIT_CYCLES   = 812242
) (
  input logic               clk,
  input logic               resetn,
  frame_sequencer_if.slave  bus
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [CTR_W-1:0] DRAW_LAST   = CTR_W'(DRAW_CYCLES - 1);
  localparam logic [CTR_W-1:0] PLAYER_LAST = CTR_W'(PLAYER_CYCLES - 1);
  localparam logic [CTR_W-1:0] ERASE_LAST  = CTR_W'(ERASE_CYCLES - 1);
  localparam logic [CTR_W-1:0] WAIT_LAST   = CTR_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT, S_ERASE, S_DRAWPLAYER, S_DRAW, S_GAMEOVER
  } state_e;

  state_e               state_q, state_d;
  logic [CTR_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 fd_q, fd_d;

  logic [CTR_W-1:0]     last_cnt;
  logic                 is_last;
  logic [NUM_LANES-1:0] rem;

  function automatic logic [LANE_W-1:0] lowest_set(input logic [NUM_LANES-1:0] m);
    lowest_set = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i]) lowest_set = LANE_W'(i);
  endfunction

  always_comb begin
    last_cnt = '0;
    case (state_q)
      S_WAIT:       last_cnt = WAIT_LAST;
      S_ERASE:      last_cnt = ERASE_LAST;
      S_DRAWPLAYER: last_cnt = PLAYER_LAST;
      S_DRAW:       last_cnt = DRAW_LAST;
      default:      last_cnt = '0;
    endcase
    is_last = (cnt_q == last_cnt);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    pend_d  = pend_q;
    lane_d  = lane_q;
    fd_d    = 1'b0;
    // pending set with the lane currently being drawn retired
    rem          = pend_q;
    rem[lane_q]  = 1'b0;
    case (state_q)
      S_WAIT: begin
`ifdef FRAME_SEQUENCER_PAUSE_EN
        if (bus.pause) cnt_d = cnt_q;
        else
`endif
        if (is_last) begin
          pend_d  = bus.lane_enable;  // the only point lane_enable is looked at
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        if (is_last) begin
          state_d = S_DRAWPLAYER;
          cnt_d   = '0;
        end
      end
      S_DRAWPLAYER: begin
        if (is_last) begin
          cnt_d = '0;
          if (bus.collide_yes) begin
            state_d = S_GAMEOVER;
          end else if (pend_q == '0) begin
            state_d = S_WAIT;
            fd_d    = 1'b1;
          end else begin
            state_d = S_DRAW;
            lane_d  = lowest_set(pend_q);
          end
        end
      end
      S_DRAW: begin
        if (is_last) begin
          cnt_d  = '0;
          pend_d = rem;
          if (bus.collide_yes) begin
            state_d = S_GAMEOVER;
          end else if (rem == '0) begin
            state_d = S_WAIT;
            fd_d    = 1'b1;
          end else begin
            lane_d = lowest_set(rem);  // stay in DRAW on the next lane
          end
        end
      end
      default: begin  // GAMEOVER: absorbing, counter parked
        state_d = S_GAMEOVER;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      pend_q  <= '0;
      lane_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.wait_enable        = (state_q == S_WAIT);
  assign bus.erase_enable       = (state_q == S_ERASE);
  assign bus.draw_player_enable = (state_q == S_DRAWPLAYER);
  assign bus.draw_enable        = (state_q == S_DRAW);
  assign bus.game_over          = (state_q == S_GAMEOVER);
  assign bus.draw_lane          = lane_q;
  assign bus.frame_done         = fd_q;
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter NUM_LANES, 3, number of NPC lanes and bits in lane_enable.
REQ-002 Parameter CTR_W, 20, phase counter width; it SHALL hold every *_CYCLES value.
REQ-003 Parameter DRAW_CYCLES, 630, clocks per NPC car draw.
REQ-004 Parameter PLAYER_CYCLES, 630, clocks per player draw.
REQ-005 Parameter ERASE_CYCLES, 19200, clocks per screen erase.
REQ-006 Parameter WAIT_CYCLES, 812242, clocks of idle per frame.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 resetn  input  1  synchronous, active-low reset.
REQ-009 lane_enable  input  NUM_LANES  one bit per lane; a set bit requests an NPC car drawn in that lane.
REQ-010 collide_yes  input  1  collision flag from the datapath.
REQ-011 erase_enable  output  1  high throughout ERASE.
REQ-012 draw_player_enable  output  1  high throughout DRAWPLAYER.
REQ-013 draw_enable  output  1  high throughout DRAW.
REQ-014 draw_lane  output  $clog2(NUM_LANES) (min 1)  index of the lane being drawn; valid while draw_enable is high.
REQ-015 wait_enable  output  1  high throughout WAIT.
REQ-016 frame_done  output  1  one-cycle pulse on the DRAW/DRAWPLAYER->WAIT transition cycle.
REQ-017 game_over  output  1  high in GAMEOVER.

Function
REQ-018 States SHALL be WAIT, ERASE, DRAWPLAYER, DRAW, GAMEOVER; outputs SHALL be decoded from the registered state only.
REQ-019 One shared CTR_W-bit phase counter SHALL clear on every state or lane change and increment each cycle; a phase ends on the cycle the counter equals its *_CYCLES-1, so each phase lasts exactly *_CYCLES cycles.
REQ-020 WAIT end SHALL latch lane_enable into a pending mask and go to ERASE; lane_enable changes at any other time SHALL have no effect on the current frame.
REQ-021 ERASE end SHALL go to DRAWPLAYER.
REQ-022 DRAWPLAYER end: pending mask zero -> WAIT with frame_done; else -> DRAW with draw_lane = lowest set pending bit.
REQ-023 DRAW end: that lane's pending bit SHALL clear; if bits remain, stay in DRAW, counter cleared, draw_lane = next lowest set bit; else -> WAIT with frame_done.
REQ-024 collide_yes SHALL be sampled only on the last cycle of a DRAWPLAYER or DRAW phase; if high, next state SHALL be GAMEOVER, with priority over all other transitions, and frame_done SHALL NOT pulse.
REQ-025 GAMEOVER SHALL be absorbing until resetn is low; all enables SHALL be low there.
REQ-026 All NUM_LANES bits set SHALL yield NUM_LANES consecutive DRAW phases of DRAW_CYCLES each, in ascending lane order.
REQ-027 Counter SHALL never wrap: the terminal compare bounds it to *_CYCLES-1.

Reset
REQ-028 resetn low at a clock edge SHALL, from any state including mid-phase, force WAIT, counter 0, pending mask 0, draw_lane 0.
REQ-029 Outputs after reset: wait_enable 1; erase_enable, draw_player_enable, draw_enable, frame_done, game_over all 0.

Configuration
REQ-030 Macro FRAME_SEQUENCER_PAUSE_EN defined: adds input pause (1 bit); while pause is high in WAIT, the counter SHALL hold and WAIT SHALL not end; pause SHALL have no effect in any other state.
REQ-031 Macro undefined: no pause port exists; WAIT always lasts exactly WAIT_CYCLES.

Verification (DRAW_CYCLES=2, PLAYER_CYCLES=2, ERASE_CYCLES=4, WAIT_CYCLES=3, NUM_LANES=3)
REQ-032 Reset then lane_enable=3'b000 -> WAIT 3, ERASE 4, DRAWPLAYER 2, then WAIT with frame_done pulse; 9-cycle frame period.
REQ-033 lane_enable=3'b101 -> DRAW 4 cycles, draw_lane 0,0,2,2; frame_done on the following transition cycle.
REQ-034 lane_enable=3'b111 latched, then changed to 3'b000 during ERASE -> still three DRAW phases, draw_lane 0,0,1,1,2,2.
REQ-035 collide_yes high on the last DRAW cycle of lane 0 with mask 3'b011 -> GAMEOVER next cycle, no lane 1 draw, no frame_done, stays in GAMEOVER until resetn=0 -> WAIT.
REQ-036 resetn low during the 3rd ERASE cycle -> next cycle WAIT, wait_enable=1, counter restarts, full 3-cycle WAIT.
REQ-037 With FRAME_SEQUENCER_PAUSE_EN: pause high for 5 cycles mid-WAIT -> WAIT lasts 8 cycles; pause high during DRAW -> no stretch.
